ifu_ctrl: RTL

IFU_CTRL -- requirements
Module: ifu_ctrl

---
 rtl/ifu_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/ifu_ctrl.sv
// Instruction fetch controller: turns single-cycle fetch requests into one bus read
// at a time and returns the instruction word, with alignment and bus error pulses.
module ifu_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rd_cmd,
    output logic [DATA_WIDTH-1:0] o_instr_dat,
    output logic                  o_busy,
    output logic                  o_err_align,
    output logic                  o_err_bus,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic                  o_bus_cmd,
    input  logic                  i_bus_ack,
    input  logic                  i_bus_rdy,
    input  logic [DATA_WIDTH-1:0] i_bus_data,
    input  logic                  i_bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  busy_q, busy_d;
    logic                  err_align_q, err_align_d;
    logic                  err_bus_q, err_bus_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic                  bus_cmd_q, bus_cmd_d;
    logic                  done;

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        busy_d      = busy_q;
        err_align_d = 1'b0;
        err_bus_d   = 1'b0;
        bus_addr_d  = bus_addr_q;
        bus_cmd_d   = bus_cmd_q;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_rd_cmd) begin
                    if (i_addr[1:0] == 2'b00) begin
                        bus_addr_d = i_addr;
                        bus_cmd_d  = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = CMD;
                    end else begin
                        err_align_d = 1'b1;
                        instr_d     = '0;
                    end
                end
            end
            CMD: begin
                if (i_bus_ack) begin
                    bus_cmd_d = 1'b0;
                    // a zero-wait bus may return data in the same cycle it accepts
                    if (i_bus_rdy) done = 1'b1;
                    else           state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_bus_rdy) done = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (i_bus_err) begin
                instr_d   = '0;
                err_bus_d = 1'b1;
            end else begin
                instr_d = i_bus_data;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            busy_q      <= 1'b0;
            err_align_q <= 1'b0;
            err_bus_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_cmd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            busy_q      <= busy_d;
            err_align_q <= err_align_d;
            err_bus_q   <= err_bus_d;
            bus_addr_q  <= bus_addr_d;
            bus_cmd_q   <= bus_cmd_d;
        end
    end

    assign o_instr_dat = instr_q;
    assign o_busy      = busy_q;
    assign o_err_align = err_align_q;
    assign o_err_bus   = err_bus_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_cmd   = bus_cmd_q;

endmodule
